// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline request, multi-cycle result channel and register-file write.
// The arbiter takes the slave side; whoever drives the requests takes the master side.
interface wb_port_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [3:0]  buf_count;

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output mc_ready, pipe_stall, rf_we, rf_rd, rf_wdata, buf_count
    );

    modport master (
        output pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, pipe_stall, rf_we, rf_rd, rf_wdata, buf_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued multi-cycle results.
// Optional WB_PERF_EN adds saturating stall/kill performance counters.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    wb_port_arbiter_if.slave bus
`ifdef WB_PERF_EN
    ,
    output logic [15:0]      perf_stalls,
    output logic [15:0]      perf_kills
`endif
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam logic [3:0]  DepthC = 4'(DEPTH);
    localparam logic [3:0]  LimitC = 4'(STARVE_LIMIT);

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic [31:0]     data_mem_d [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic [3:0]      starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [31:0]     rf_wdata_q, rf_wdata_d;

    logic empty, stall, pipe_req, push, head_grant, pipe_grant, head_kill;

    assign empty      = (count_q == 4'd0);
    assign stall      = (starve_q == LimitC) && !empty;
    assign pipe_req   = bus.pipe_we && (bus.pipe_rd != 5'd0);
    // x0 results are accepted off the channel but never stored
    assign push       = bus.mc_valid && (count_q < DepthC) && (bus.mc_rd != 5'd0);
    assign pipe_grant = !stall && pipe_req;
    assign head_grant = stall || (!pipe_req && !empty);
    assign head_kill  = kill_q[rd_ptr_q];

    assign bus.mc_ready   = (count_q < DepthC);
    assign bus.pipe_stall = stall;
    assign bus.buf_count  = count_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        kill_d     = kill_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = 5'd0;
        rf_wdata_d = 32'd0;

        if (pipe_grant) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = bus.pipe_rd;
            rf_wdata_d = bus.pipe_data;
            // Stale flags on empty slots are harmless: a push always clears its own flag
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_mem_q[i] == bus.pipe_rd) kill_d[i] = 1'b1;
            end
        end else if (head_grant && !head_kill) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = rd_mem_q[rd_ptr_q];
            rf_wdata_d = data_mem_q[rd_ptr_q];
        end

        if (head_grant) rd_ptr_d = rd_ptr_q + PtrW'(1);

        if (push) begin
            rd_mem_d[wr_ptr_q]   = bus.mc_rd;
            data_mem_d[wr_ptr_q] = bus.mc_data;
            kill_d[wr_ptr_q]     = 1'b0;
            wr_ptr_d             = wr_ptr_q + PtrW'(1);
        end

        count_d = count_q + {3'b000, push} - {3'b000, head_grant};

        starve_d = starve_q;
        if (head_grant || empty) begin
            starve_d = 4'd0;
        end else if (pipe_grant && (starve_q != LimitC)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
            kill_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            starve_q   <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            kill_q     <= kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WB_PERF_EN
    logic [15:0] perf_stalls_q, perf_stalls_d, perf_kills_q, perf_kills_d;

    always_comb begin
        perf_stalls_d = perf_stalls_q;
        perf_kills_d  = perf_kills_q;
        if (stall && (perf_stalls_q != 16'hFFFF)) perf_stalls_d = perf_stalls_q + 16'd1;
        if (head_grant && head_kill && (perf_kills_q != 16'hFFFF)) begin
            perf_kills_d = perf_kills_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stalls_q <= 16'd0;
            perf_kills_q  <= 16'd0;
        end else begin
            perf_stalls_q <= perf_stalls_d;
            perf_kills_q  <= perf_kills_d;
        end
    end

    assign perf_stalls = perf_stalls_q;
    assign perf_kills  = perf_kills_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4) with hand-computed expectations.
module tb_wb_port_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wb_port_arbiter_if bus ();

`ifdef WB_PERF_EN
    logic [15:0] perf_stalls;
    logic [15:0] perf_kills;
`endif

    wb_port_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef WB_PERF_EN
        ,
        .perf_stalls (perf_stalls),
        .perf_kills  (perf_kills)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
        bus.pipe_we   = pwe;
        bus.pipe_rd   = prd;
        bus.pipe_data = pdata;
        bus.mc_valid  = mv;
        bus.mc_rd     = mrd;
        bus.mc_data   = mdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_rf_we", {31'd0, bus.rf_we}, 32'd0);
        check("reset_rf_rd", {27'd0, bus.rf_rd}, 32'd0);
        check("reset_rf_wdata", bus.rf_wdata, 32'd0);
        check("reset_stall", {31'd0, bus.pipe_stall}, 32'd0);
        check("reset_count", {28'd0, bus.buf_count}, 32'd0);
        check("reset_ready", {31'd0, bus.mc_ready}, 32'd1);

        // Pipe only
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("pipe_we", {31'd0, bus.rf_we}, 32'd1);
        check("pipe_rd", {27'd0, bus.rf_rd}, 32'd5);
        check("pipe_data", bus.rf_wdata, 32'h1234);
        check("pipe_count", {28'd0, bus.buf_count}, 32'd0);
        tick();
        check("pipe_idle_we", {31'd0, bus.rf_we}, 32'd0);

        // MC into idle port
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("mc_count1", {28'd0, bus.buf_count}, 32'd1);
        check("mc_no_write_yet", {31'd0, bus.rf_we}, 32'd0);
        tick();
        check("mc_we", {31'd0, bus.rf_we}, 32'd1);
        check("mc_rd", {27'd0, bus.rf_rd}, 32'd7);
        check("mc_data", bus.rf_wdata, 32'hDEAD);
        check("mc_count0", {28'd0, bus.buf_count}, 32'd0);

        // Starvation
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd3, 32'h3000 + k, 1'b0, 5'd0, 32'd0);
            check("starve_no_stall", {31'd0, bus.pipe_stall}, 32'd0);
            tick();
            check("starve_pipe_rd", {27'd0, bus.rf_rd}, 32'd3);
            check("starve_pipe_data", bus.rf_wdata, 32'h3000 + k);
        end
        check("starve_stall", {31'd0, bus.pipe_stall}, 32'd1);
        tick();
        check("starve_head_rd", {27'd0, bus.rf_rd}, 32'd9);
        check("starve_head_data", bus.rf_wdata, 32'h9999);
        check("starve_count", {28'd0, bus.buf_count}, 32'd0);
        check("starve_cleared", {31'd0, bus.pipe_stall}, 32'd0);
        tick();
        check("starve_repres_rd", {27'd0, bus.rf_rd}, 32'd3);

        // WAW kill
        drive(1'b1, 5'd1, 32'h1111, 1'b1, 5'd4, 32'hAAAA);
        tick();
        drive(1'b1, 5'd4, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("waw_pipe_rd", {27'd0, bus.rf_rd}, 32'd4);
        check("waw_pipe_data", bus.rf_wdata, 32'hBBBB);
        tick();
        check("waw_kill_we", {31'd0, bus.rf_we}, 32'd0);
        check("waw_kill_data", bus.rf_wdata, 32'd0);
        check("waw_kill_count", {28'd0, bus.buf_count}, 32'd0);

        // Same-cycle push survives a pipe write to the same rd
        drive(1'b1, 5'd6, 32'h6000, 1'b1, 5'd6, 32'h6666);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("samecyc_pipe_data", bus.rf_wdata, 32'h6000);
        tick();
        check("samecyc_mc_we", {31'd0, bus.rf_we}, 32'd1);
        check("samecyc_mc_data", bus.rf_wdata, 32'h6666);

        // Full / back-pressure with continuous pipe traffic
        drive(1'b1, 5'd2, 32'h2000, 1'b1, 5'd10, 32'hA1);
        tick();
        drive(1'b1, 5'd2, 32'h2000, 1'b1, 5'd11, 32'hA2);
        check("full_ready_1", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        drive(1'b1, 5'd2, 32'h2000, 1'b1, 5'd12, 32'hA3);
        check("full_ready_0", {31'd0, bus.mc_ready}, 32'd0);
        tick();
        check("full_count_held", {28'd0, bus.buf_count}, 32'd2);
        tick();
        tick();
        check("full_stall", {31'd0, bus.pipe_stall}, 32'd1);
        check("full_no_credit", {31'd0, bus.mc_ready}, 32'd0);
        tick();
        check("full_pop_rd", {27'd0, bus.rf_rd}, 32'd10);
        check("full_pop_data", bus.rf_wdata, 32'hA1);
        check("full_count_1", {28'd0, bus.buf_count}, 32'd1);
        check("full_ready_back", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        drive(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
        check("full_third_in", {28'd0, bus.buf_count}, 32'd2);
        check("full_pipe_rd", {27'd0, bus.rf_rd}, 32'd2);
        tick();
        check("x0pipe_head_rd", {27'd0, bus.rf_rd}, 32'd11);
        tick();
        check("drain_rd", {27'd0, bus.rf_rd}, 32'd12);
        check("drain_data", bus.rf_wdata, 32'hA3);
        check("drain_count", {28'd0, bus.buf_count}, 32'd0);
        tick();
        check("x0pipe_no_write", {31'd0, bus.rf_we}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        check("x0mc_ready", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("x0mc_count", {28'd0, bus.buf_count}, 32'd0);
        tick();
        check("x0mc_no_write", {31'd0, bus.rf_we}, 32'd0);

        // Reset mid-operation
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd13, 32'hC1);
        tick();
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd14, 32'hC2);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("mid_count2", {28'd0, bus.buf_count}, 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_count", {28'd0, bus.buf_count}, 32'd0);
        check("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("mid_rst_stall", {31'd0, bus.pipe_stall}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.mc_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_no_stale_we", {31'd0, bus.rf_we}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback result (post MemtoReg mux) and a multi-cycle execution unit (divider / long-latency load) that completes out of band. Multi-cycle results are queued in a small FIFO and drained into idle write-port cycles. A starvation counter forces a one-cycle pipeline stall so that queued results cannot be held off indefinitely. Sits between the WB stage and the register file.

Parameters:
DEPTH, 2, FIFO entries for multi-cycle results (power of two, 2..8)
STARVE_LIMIT, 4, consecutive pipe-won cycles with a non-empty FIFO before a forced stall (1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
pipe_we  input  1  pipeline WB write request
pipe_rd  input  5  pipeline destination register
pipe_data  input  32  pipeline writeback data (ALU or memory result)
mc_valid  input  1  multi-cycle unit result valid
mc_rd  input  5  multi-cycle destination register
mc_data  input  32  multi-cycle result data
mc_ready  output  1  FIFO can accept; transfer when mc_valid & mc_ready
pipe_stall  output  1  pipeline must hold its WB instruction this cycle
rf_we  output  1  register-file write enable (registered)
rf_rd  output  5  register-file write address (registered)
rf_wdata  output  32  register-file write data (registered)
buf_count  output  4  current FIFO occupancy

Behaviour:
- Reset is synchronous, active-low, and has priority over all other events. On reset: rf_we=0, rf_rd=0, rf_wdata=0, pipe_stall=0, buf_count=0. The FIFO is emptied, all kill flags are cleared and the starvation counter is set to 0. Any entry in flight is lost.
- mc_ready = (buf_count < DEPTH). It is combinational from state only and gives no pop-through credit. A full FIFO deasserts mc_ready even when a pop happens in the same cycle.
- Accepted mc with mc_rd==0 is consumed and discarded. It is not stored and buf_count does not change.
- pipe_stall = (starve_cnt == STARVE_LIMIT) & FIFO non-empty. It is combinational from registered state.
- Grant priority each cycle:
  1. If pipe_stall=1, the FIFO head wins and pipe_we is ignored; the pipeline re-presents its request next cycle.
  2. Else if pipe_we=1 and pipe_rd!=0, the pipe wins.
  3. Else if the FIFO is non-empty, the head wins.
  4. Else there is no write.
- A pipe request with rd==0 is treated as no request.
- The winner is registered onto rf_we/rf_rd/rf_wdata at the next edge. Write latency is 1 cycle for the pipe. For mc it is at least 2 cycles: push at edge N, earliest rf_we at edge N+1.
- A granted pop removes the head. If the head's kill flag is set, it is popped with rf_we=0 and still counts as a head grant.
- WAW kill: when the pipe is granted with rd=R, every entry already in the FIFO at that edge whose rd==R gets its kill flag set. An mc entry pushed in the same cycle is not killed.
- Push and pop in the same cycle are allowed (count unchanged). Pointers wrap modulo DEPTH.
- Starvation counter:
  - Increments when the pipe wins while the FIFO is non-empty.
  - Clears to 0 on any head grant or whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Pipe writes and FIFO writes never both reach the register file in the same cycle.

Optional Feature:
WB_PERF_EN:
- Defined: adds output ports perf_stalls[15:0] and perf_kills[15:0]. These are saturating counts of pipe_stall cycles and of killed pops, cleared by reset.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Pipe only: pipe_we=1, rd=5, data=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234; mc_ready=1, buf_count=0 throughout.
- MC into idle port: mc_valid=1, rd=7, data=0xDEAD at cycle 0, no pipe traffic -> buf_count=1 after edge 0; rf_we=1, rf_rd=7 after edge 1; buf_count back to 0.
- Starvation: push rd=9, then pipe_we=1 every cycle with rd=3 -> pipe wins 4 cycles; pipe_stall=1 in cycle 5; rf_rd=9 written the following cycle; starve_cnt clears.
- WAW kill: FIFO holds rd=4 (0xAAAA); pipe writes rd=4 (0xBBBB) -> rf gets 0xBBBB; the later pop of the rd=4 entry produces rf_we=0; rf_rd never shows 0xAAAA data.
- Full/back-pressure with DEPTH=2: three consecutive mc_valid with continuous pipe traffic -> mc_ready=0 after 2 pushes; third held until a pop; x0 write (mc_rd=0) accepted without occupancy change.
- Reset mid-operation: FIFO at 2 entries, rst_n=0 for one edge -> buf_count=0, rf_we=0, pipe_stall=0, mc_ready=1; no stale entry is ever written afterward.
